// File: rtl/led_pkg.sv
// Shared timing constants and pixel layout for the addressable-LED encoder/decoder pair.
// All cycle counts refer to the 10 MHz CLOCK_10 domain.
package led_pkg;

   localparam int T0H            = 4;
   localparam int T1H            = 8;
   localparam int BIT_PERIOD_0   = 12;
   localparam int BIT_PERIOD_1   = 13;
   localparam int LATCH_CYCLES   = 500;
   localparam int BITS_PER_PIXEL = 24;

   localparam int G_OFS = 16;
   localparam int R_OFS = 8;
   localparam int B_OFS = 0;

   // Wire order is G first, MSB first, so a packed struct maps the shift register directly.
   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } grb_t;

endpackage

// File: rtl/led_pixel_decoder_pin_sync.sv
// Two-flop synchronizer for the serial data line with single-cycle rise/fall detection
// on the synchronized value.
module pin_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic s,
   output logic rise,
   output logic fall
);

   logic meta_r;
   logic sync_r;
   logic prev_r;

   // Synchronizer chain plus one history flop for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
         prev_r <= 1'b0;
      end else begin
         meta_r <= din;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign s    = sync_r;
   assign rise = sync_r & ~prev_r;
   assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/led_pixel_decoder.sv
// Single-wire addressable-LED receiver: classifies high pulses into bits, assembles GRB
// pixels, and reports frame latches and malformed input.
module led_pixel_decoder
   import led_pkg::*;
#(
   parameter int MIN_HIGH     = 2,
   parameter int THRESH       = 6,
   parameter int MAX_HIGH     = 11,
   parameter int LATCH_CYCLES = led_pkg::LATCH_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_pin,
   output logic [7:0] r,
   output logic [7:0] g,
   output logic [7:0] b,
   output logic       valid,
   output logic [9:0] pixel_index,
   output logic       latch,
   output logic       err
);

   localparam logic [0:0] ST_LOW  = 1'b0;
   localparam logic [0:0] ST_HIGH = 1'b1;

   localparam logic [3:0] MIN_L    = 4'(MIN_HIGH);
   localparam logic [3:0] THRESH_L = 4'(THRESH);
   localparam logic [3:0] MAX_L    = 4'(MAX_HIGH);
   localparam logic [9:0] LATCH_L  = 10'(LATCH_CYCLES);
   localparam logic [4:0] LAST_BIT = 5'(BITS_PER_PIXEL - 1);

   logic        s_s;
   logic        rise_s;
   logic        fall_s;

   logic [0:0]  state_r;
   logic [3:0]  high_cnt_r;
   logic [9:0]  low_cnt_r;
   logic [4:0]  bit_cnt_r;
   logic [23:0] shift_r;
   logic [9:0]  idx_r;
   logic        armed_r;
   logic        frame_active_r;
   logic        latch_done_r;

   logic        bad_width_s;
   logic        bit_s;
   grb_t        word_s;
   logic        lat_hit_s;

   pin_sync u_pin_sync (
      .clk   (clk),
      .reset (reset),
      .din   (data_pin),
      .s     (s_s),
      .rise  (rise_s),
      .fall  (fall_s)
   );

   // Pulse classification and latch-point detection.
   always_comb begin
      bad_width_s = 1'b0;
      bit_s       = 1'b0;
      word_s      = '0;
      lat_hit_s   = 1'b0;
      bad_width_s = (high_cnt_r < MIN_L) || (high_cnt_r > MAX_L);
      bit_s       = (high_cnt_r >= THRESH_L);
      word_s      = {shift_r[22:0], bit_s};
      lat_hit_s   = (state_r == ST_LOW) && (low_cnt_r == LATCH_L) && !latch_done_r;
   end

   // Pulse-width FSM, pixel assembly, frame tracking and registered strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_LOW;
         high_cnt_r     <= 4'd0;
         low_cnt_r      <= 10'd0;
         bit_cnt_r      <= 5'd0;
         shift_r        <= 24'd0;
         idx_r          <= 10'd0;
         armed_r        <= 1'b0;
         frame_active_r <= 1'b0;
         latch_done_r   <= 1'b0;
         r              <= 8'd0;
         g              <= 8'd0;
         b              <= 8'd0;
         valid          <= 1'b0;
         pixel_index    <= 10'd0;
         latch          <= 1'b0;
         err            <= 1'b0;
      end else begin
         valid <= 1'b0;
         latch <= 1'b0;
         err   <= 1'b0;

         case (state_r)
            ST_LOW: begin
               if (rise_s) begin
                  // The rising cycle itself is the first high cycle of the pulse.
                  state_r    <= ST_HIGH;
                  high_cnt_r <= 4'd1;
                  low_cnt_r  <= 10'd0;
               end else if (low_cnt_r != LATCH_L) begin
                  low_cnt_r <= low_cnt_r + 10'd1;
               end
            end
            ST_HIGH: begin
               if (fall_s) begin
                  state_r      <= ST_LOW;
                  low_cnt_r    <= 10'd1;
                  latch_done_r <= 1'b0;
                  if (armed_r) begin
                     if (bad_width_s) begin
                        err       <= 1'b1;
                        bit_cnt_r <= 5'd0;
                        armed_r   <= 1'b0;
                     end else begin
                        shift_r <= word_s;
                        if (bit_cnt_r == LAST_BIT) begin
                           g              <= word_s.g;
                           r              <= word_s.r;
                           b              <= word_s.b;
                           valid          <= 1'b1;
                           pixel_index    <= idx_r;
                           idx_r          <= idx_r + 10'd1;
                           bit_cnt_r      <= 5'd0;
                           frame_active_r <= 1'b1;
                        end else begin
                           bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                     end
                  end
               end else if (high_cnt_r != 4'd15) begin
                  high_cnt_r <= high_cnt_r + 4'd1;
               end
            end
            default: begin
               state_r <= ST_LOW;
            end
         endcase

         // A latch-length low ends any frame, drops a partial pixel and re-arms.
         if (lat_hit_s) begin
            latch_done_r <= 1'b1;
            armed_r      <= 1'b1;
            if (frame_active_r || (bit_cnt_r != 5'd0)) begin
               latch          <= 1'b1;
               idx_r          <= 10'd0;
               frame_active_r <= 1'b0;
            end
            if (bit_cnt_r != 5'd0) begin
               err       <= 1'b1;
               bit_cnt_r <= 5'd0;
            end
         end
      end
   end

endmodule

// File: tb/tb_led_pixel_decoder.sv
// Directed self-checking bench for led_pixel_decoder: pixels are driven as encoder-style
// pulses and every decoded strobe is logged by a negedge monitor.
module tb_led_pixel_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       data_pin = 1'b0;
   logic [7:0] r, g, b;
   logic       valid, latch, err;
   logic [9:0] pixel_index;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int last_fall = 0;

   int valid_cnt = 0;
   int latch_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int last_latch_cyc = 0;
   int last_err_cyc = 0;
   logic [9:0] v_idx [0:255];
   logic [7:0] v_r   [0:255];
   logic [7:0] v_g   [0:255];
   logic [7:0] v_b   [0:255];
   int         v_cyc [0:255];

   led_pixel_decoder dut (
      .clk         (clk),
      .reset       (reset),
      .data_pin    (data_pin),
      .r           (r),
      .g           (g),
      .b           (b),
      .valid       (valid),
      .pixel_index (pixel_index),
      .latch       (latch),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every strobe away from the active edge.
   always @(negedge clk) begin
      if (valid) begin
         v_idx[valid_cnt[7:0]] <= pixel_index;
         v_r[valid_cnt[7:0]]   <= r;
         v_g[valid_cnt[7:0]]   <= g;
         v_b[valid_cnt[7:0]]   <= b;
         v_cyc[valid_cnt[7:0]] <= cyc;
         valid_cnt <= valid_cnt + 1;
      end
      if (latch) begin
         latch_cnt      <= latch_cnt + 1;
         last_latch_cyc <= cyc;
      end
      if (err) begin
         err_cnt      <= err_cnt + 1;
         last_err_cyc <= cyc;
      end
      if (valid && latch) both_cnt <= both_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_pulse(input int hi, input int lo);
      data_pin = 1'b1;
      tick(hi);
      data_pin = 1'b0;
      last_fall = cyc;
      tick(lo);
   endtask

   task automatic send_pixel(input logic [23:0] w);
      for (int i = 23; i >= 0; i--) begin
         if (w[i]) send_pulse(8, 5);
         else      send_pulse(4, 8);
      end
      tick(4);
   endtask

   task automatic idle(input int n);
      data_pin = 1'b0;
      tick(n);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      data_pin = 1'b0;
      tick(4);
      checks++;
      if ({r, g, b} !== 24'h000000) begin
         errors++; $display("FAIL reset_rgb got %h want 000000", {r, g, b});
      end
      checks++;
      if (pixel_index !== 10'd0) begin
         errors++; $display("FAIL reset_index got %0d want 0", pixel_index);
      end
      checks++;
      if ({valid, latch, err} !== 3'b000) begin
         errors++; $display("FAIL reset_strobes got %b want 000", {valid, latch, err});
      end
      reset = 1'b0;
   endtask

   task automatic test_unarmed;
      int v0 = valid_cnt;
      int e0 = err_cnt;
      int l0 = latch_cnt;
      send_pixel(24'hFF00FF);
      send_pixel(24'h123456);
      checks++;
      if (valid_cnt - v0 !== 0) begin
         errors++; $display("FAIL unarmed_valid got %0d want 0", valid_cnt - v0);
      end
      checks++;
      if (err_cnt - e0 !== 0) begin
         errors++; $display("FAIL unarmed_err got %0d want 0", err_cnt - e0);
      end
      idle(600);
      checks++;
      if (latch_cnt - l0 !== 0) begin
         errors++; $display("FAIL unarmed_latch got %0d want 0", latch_cnt - l0);
      end
   endtask

   task automatic test_single_pixel;
      int v0 = valid_cnt;
      send_pixel(24'h123456);
      checks++;
      if (valid_cnt - v0 !== 1) begin
         errors++; $display("FAIL single_count got %0d want 1", valid_cnt - v0);
      end
      checks++;
      if ({v_g[v0], v_r[v0], v_b[v0]} !== 24'h123456) begin
         errors++; $display("FAIL single_grb got %h want 123456", {v_g[v0], v_r[v0], v_b[v0]});
      end
      checks++;
      if (v_idx[v0] !== 10'd0) begin
         errors++; $display("FAIL single_index got %0d want 0", v_idx[v0]);
      end
      checks++;
      if (v_cyc[v0] - last_fall !== 3) begin
         errors++; $display("FAIL single_latency got %0d want 3", v_cyc[v0] - last_fall);
      end
      checks++;
      if ({r, g, b} !== 24'h341256) begin
         errors++; $display("FAIL single_hold got %h want 341256", {r, g, b});
      end
   endtask

   task automatic test_frame;
      int v0, l0, e0;
      logic [7:0] p;
      l0 = latch_cnt;
      idle(600);
      checks++;
      if (latch_cnt - l0 !== 1) begin
         errors++; $display("FAIL frame_prelatch got %0d want 1", latch_cnt - l0);
      end
      v0 = valid_cnt;
      for (int i = 0; i < 64; i++) begin
         p = 8'(i * 4);
         send_pixel({p, p, p});
      end
      checks++;
      if (valid_cnt - v0 !== 64) begin
         errors++; $display("FAIL frame_count got %0d want 64", valid_cnt - v0);
      end
      for (int i = 0; i < 64; i++) begin
         p = 8'(i * 4);
         checks++;
         if ({v_idx[v0 + i], v_g[v0 + i], v_b[v0 + i]} !== {10'(i), p, p}) begin
            errors++;
            $display("FAIL frame_pixel%0d got idx=%0d g=%h b=%h want idx=%0d g=%h b=%h",
                     i, v_idx[v0 + i], v_g[v0 + i], v_b[v0 + i], i, p, p);
         end
      end
      l0 = latch_cnt;
      e0 = err_cnt;
      idle(600);
      checks++;
      if (latch_cnt - l0 !== 1) begin
         errors++; $display("FAIL frame_latch got %0d want 1", latch_cnt - l0);
      end
      checks++;
      if (err_cnt - e0 !== 0) begin
         errors++; $display("FAIL frame_latch_err got %0d want 0", err_cnt - e0);
      end
      v0 = valid_cnt;
      send_pixel(24'hABCDEF);
      checks++;
      if ({v_idx[v0], v_r[v0]} !== {10'd0, 8'hCD}) begin
         errors++; $display("FAIL frame_restart got idx=%0d r=%h want idx=0 r=cd", v_idx[v0], v_r[v0]);
      end
   endtask

   task automatic test_glitch;
      int v0, e0;
      logic [23:0] w = 24'hF0F0F0;
      idle(600);
      v0 = valid_cnt;
      e0 = err_cnt;
      for (int i = 23; i > 13; i--) send_pulse(w[i] ? 8 : 4, w[i] ? 5 : 8);
      send_pulse(1, 8);
      checks++;
      if (err_cnt - e0 !== 1) begin
         errors++; $display("FAIL glitch_err got %0d want 1", err_cnt - e0);
      end
      checks++;
      if (last_err_cyc - last_fall !== 3) begin
         errors++; $display("FAIL glitch_err_latency got %0d want 3", last_err_cyc - last_fall);
      end
      for (int i = 13; i >= 0; i--) send_pulse(w[i] ? 8 : 4, w[i] ? 5 : 8);
      send_pixel(24'h0F0F0F);
      checks++;
      if ({valid_cnt - v0, err_cnt - e0} !== {32'd0, 32'd1}) begin
         errors++; $display("FAIL glitch_ignored got valid=%0d err=%0d want valid=0 err=1",
                            valid_cnt - v0, err_cnt - e0);
      end
      idle(600);
      send_pixel(24'hA55AC3);
      checks++;
      if ({v_g[v0], v_r[v0], v_b[v0], v_idx[v0]} !== {24'hA55AC3, 10'd0} || valid_cnt - v0 !== 1) begin
         errors++; $display("FAIL glitch_recover got grb=%h idx=%0d n=%0d want grb=a55ac3 idx=0 n=1",
                            {v_g[v0], v_r[v0], v_b[v0]}, v_idx[v0], valid_cnt - v0);
      end
   endtask

   task automatic test_truncated;
      int v0, e0, l0;
      idle(600);
      v0 = valid_cnt;
      e0 = err_cnt;
      l0 = latch_cnt;
      for (int i = 0; i < 12; i++) send_pulse((i % 2 == 1) ? 8 : 4, 6);
      idle(600);
      checks++;
      if ({latch_cnt - l0, err_cnt - e0, valid_cnt - v0} !== {32'd1, 32'd1, 32'd0}) begin
         errors++; $display("FAIL trunc_counts got latch=%0d err=%0d valid=%0d want 1 1 0",
                            latch_cnt - l0, err_cnt - e0, valid_cnt - v0);
      end
      checks++;
      if (last_latch_cyc !== last_err_cyc) begin
         errors++; $display("FAIL trunc_same_cycle got latch@%0d err@%0d want equal",
                            last_latch_cyc, last_err_cyc);
      end
      send_pixel(24'h010203);
      checks++;
      if ({v_idx[v0], v_b[v0]} !== {10'd0, 8'h03}) begin
         errors++; $display("FAIL trunc_restart got idx=%0d b=%h want idx=0 b=03", v_idx[v0], v_b[v0]);
      end
   endtask

   task automatic test_boundaries;
      int v0, e0;
      int widths [4] = '{5, 6, 11, 2};
      idle(600);
      v0 = valid_cnt;
      for (int i = 0; i < 24; i++) send_pulse(widths[i % 4], 6);
      tick(4);
      checks++;
      if ({v_g[v0], v_r[v0], v_b[v0]} !== 24'h666666 || valid_cnt - v0 !== 1) begin
         errors++; $display("FAIL width_decode got grb=%h n=%0d want grb=666666 n=1",
                            {v_g[v0], v_r[v0], v_b[v0]}, valid_cnt - v0);
      end
      idle(600);
      v0 = valid_cnt;
      e0 = err_cnt;
      for (int i = 0; i < 5; i++) send_pulse(8, 5);
      send_pulse(12, 6);
      checks++;
      if ({err_cnt - e0, valid_cnt - v0} !== {32'd1, 32'd0}) begin
         errors++; $display("FAIL width_12 got err=%0d valid=%0d want err=1 valid=0",
                            err_cnt - e0, valid_cnt - v0);
      end
   endtask

   task automatic test_reset_mid;
      int v0, e0;
      idle(600);
      for (int i = 0; i < 10; i++) send_pulse(8, 5);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      v0 = valid_cnt;
      e0 = err_cnt;
      send_pixel(24'h777777);
      checks++;
      if ({valid_cnt - v0, err_cnt - e0} !== {32'd0, 32'd0}) begin
         errors++; $display("FAIL midreset_ignored got valid=%0d err=%0d want 0 0",
                            valid_cnt - v0, err_cnt - e0);
      end
      idle(600);
      send_pixel(24'h102030);
      checks++;
      if ({v_r[v0], v_idx[v0]} !== {8'h20, 10'd0} || valid_cnt - v0 !== 1) begin
         errors++; $display("FAIL midreset_recover got r=%h idx=%0d n=%0d want r=20 idx=0 n=1",
                            v_r[v0], v_idx[v0], valid_cnt - v0);
      end
   endtask

   initial begin
      test_reset();
      test_unarmed();
      test_single_pixel();
      test_frame();
      test_glitch();
      test_truncated();
      test_boundaries();
      test_reset_mid();
      checks++;
      if (both_cnt !== 0) begin
         errors++; $display("FAIL valid_latch_overlap got %0d want 0", both_cnt);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
